// File: rtl/updown_bcd_timer_if.sv
// Control and status bundle of the up/down BCD timer. The lap_hold input
// exists only when UPDOWN_TIMER_LAP_EN is defined.
interface updown_bcd_timer_if;
  logic             timer_clear;
  logic             timer_pause;
  logic             timer_start;
  logic             count_down;
  logic             load_valid;
  logic [23:0]      load_bcd;
  logic             load_err;
  logic             running;
  logic             expired;
  logic             wrap_pulse;
  logic [5:0][6:0]  digital_clock_out;
`ifdef UPDOWN_TIMER_LAP_EN
  logic             lap_hold;
`endif

  modport master (
    output timer_clear, timer_pause, timer_start, count_down, load_valid, load_bcd,
`ifdef UPDOWN_TIMER_LAP_EN
    output lap_hold,
`endif
    input  load_err, running, expired, wrap_pulse, digital_clock_out
  );

  modport slave (
    input  timer_clear, timer_pause, timer_start, count_down, load_valid, load_bcd,
`ifdef UPDOWN_TIMER_LAP_EN
    input  lap_hold,
`endif
    output load_err, running, expired, wrap_pulse, digital_clock_out
  );
endinterface

// File: rtl/updown_bcd_timer.sv
// HH:MM:SS up/down BCD timer with preload, expiry and active-low 7-segment drive.
// Optional display freeze (lap_hold) is built when UPDOWN_TIMER_LAP_EN is defined.
module updown_bcd_timer #(
  parameter int CLK_DIV = 10,
  parameter int HR_MAX  = 99
) (
  input  logic              sys_clk,
  input  logic              rst_b,
  updown_bcd_timer_if.slave bus
);

  localparam int             PW       = $clog2(CLK_DIV);
  localparam logic [PW-1:0]  DIV_LAST = PW'(CLK_DIV - 1);
  localparam logic [7:0]     HR_MAX_B = 8'(HR_MAX);
  localparam logic [3:0]     HR_T     = 4'(HR_MAX / 10);
  localparam logic [3:0]     HR_U     = 4'(HR_MAX % 10);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [5:0][3:0]  cnt_r, cnt_nxt_s, inc_s, dec_s, ld_s;
  logic [PW-1:0]    presc_r, presc_nxt_s;
  logic             mode_down_r, mode_nxt_s;
  logic             load_err_r, load_err_nxt_s;
  logic             wrap_r, wrap_nxt_s;
  logic             inc_wrap_s, dec_zero_s, cnt_zero_s, load_ok_s;
  logic [5:0][6:0]  disp_r, disp_nxt_s;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign ld_s       = bus.load_bcd;
  assign cnt_zero_s = (cnt_r == 24'd0);
  assign load_ok_s  = (ld_s[0] <= 4'd9) && (ld_s[1] <= 4'd5) && (ld_s[2] <= 4'd9) &&
                      (ld_s[3] <= 4'd5) && (ld_s[4] <= 4'd9) && (ld_s[5] <= 4'd9) &&
                      ((({4'd0, ld_s[5]} * 8'd10) + {4'd0, ld_s[4]}) <= HR_MAX_B);

  // BCD increment with carry; even digits roll at 9, odd (tens) at 5, hours at HR_MAX
  always_comb begin
    logic carry_v;
    inc_s      = cnt_r;
    inc_wrap_s = 1'b0;
    carry_v    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry_v) begin
        if (cnt_r[i] == (((i % 2) == 0) ? 4'd9 : 4'd5)) begin
          inc_s[i] = 4'd0;
        end else begin
          inc_s[i] = cnt_r[i] + 4'd1;
          carry_v  = 1'b0;
        end
      end else begin
        inc_s[i] = cnt_r[i];
      end
    end
    if (carry_v) begin
      if ((cnt_r[5] == HR_T) && (cnt_r[4] == HR_U)) begin
        inc_s[5]   = 4'd0;
        inc_s[4]   = 4'd0;
        inc_wrap_s = 1'b1;
      end else if (cnt_r[4] == 4'd9) begin
        inc_s[4] = 4'd0;
        inc_s[5] = cnt_r[5] + 4'd1;
      end else begin
        inc_s[4] = cnt_r[4] + 4'd1;
      end
    end else begin
      inc_wrap_s = 1'b0;
    end
  end

  // BCD decrement with borrow; never applied to an all-zero count
  always_comb begin
    logic borrow_v;
    dec_s    = cnt_r;
    borrow_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow_v) begin
        if (cnt_r[i] == 4'd0) begin
          dec_s[i] = ((i % 2) == 0) ? 4'd9 : 4'd5;
        end else begin
          dec_s[i] = cnt_r[i] - 4'd1;
          borrow_v = 1'b0;
        end
      end else begin
        dec_s[i] = cnt_r[i];
      end
    end
    if (borrow_v) begin
      if (cnt_r[4] == 4'd0) begin
        dec_s[4] = 4'd9;
        dec_s[5] = cnt_r[5] - 4'd1;
      end else begin
        dec_s[4] = cnt_r[4] - 4'd1;
      end
    end else begin
      dec_s[5:4] = cnt_r[5:4];
    end
  end

  assign dec_zero_s = (dec_s == 24'd0);

  // Next-state logic: clear > load > start > tick
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    presc_nxt_s    = presc_r;
    mode_nxt_s     = mode_down_r;
    load_err_nxt_s = 1'b0;
    wrap_nxt_s     = 1'b0;
    if (bus.timer_clear) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = 24'd0;
      presc_nxt_s = PW'(0);
    end else if (bus.load_valid && (state_r != ST_RUN)) begin
      if (load_ok_s) begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = ld_s;
        presc_nxt_s = PW'(0);
      end else begin
        load_err_nxt_s = 1'b1;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.timer_start && !(bus.count_down && cnt_zero_s)) begin
            state_nxt_s = ST_RUN;
            mode_nxt_s  = bus.count_down;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          // a load while running is refused but the count keeps going
          load_err_nxt_s = bus.load_valid;
          if (bus.timer_pause) begin
            presc_nxt_s = presc_r;
          end else if (presc_r == DIV_LAST) begin
            presc_nxt_s = PW'(0);
            if (mode_down_r) begin
              cnt_nxt_s = dec_s;
              if (dec_zero_s) begin
                state_nxt_s = ST_EXPIRED;
              end else begin
                state_nxt_s = ST_RUN;
              end
            end else begin
              cnt_nxt_s  = inc_s;
              wrap_nxt_s = inc_wrap_s;
            end
          end else begin
            presc_nxt_s = presc_r + PW'(1);
          end
        end
        ST_EXPIRED: begin
          if (bus.timer_start && !cnt_zero_s) begin
            state_nxt_s = ST_RUN;
            mode_nxt_s  = bus.count_down;
          end else begin
            state_nxt_s = ST_EXPIRED;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Display image of the current count, optionally frozen by lap_hold
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      disp_nxt_s[i] = seg7(cnt_r[i]);
    end
`ifdef UPDOWN_TIMER_LAP_EN
    if (bus.lap_hold && !bus.timer_clear) begin
      disp_nxt_s = disp_r;
    end else begin
      disp_nxt_s = disp_nxt_s;
    end
`endif
  end

  // State, count and output registers with synchronous active-low reset
  always_ff @(posedge sys_clk) begin
    if (!rst_b) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 24'd0;
      presc_r     <= PW'(0);
      mode_down_r <= 1'b0;
      load_err_r  <= 1'b0;
      wrap_r      <= 1'b0;
      disp_r      <= {6{7'b0000001}};
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      presc_r     <= presc_nxt_s;
      mode_down_r <= mode_nxt_s;
      load_err_r  <= load_err_nxt_s;
      wrap_r      <= wrap_nxt_s;
      disp_r      <= disp_nxt_s;
    end
  end

  assign bus.load_err          = load_err_r;
  assign bus.wrap_pulse        = wrap_r;
  assign bus.expired           = (state_r == ST_EXPIRED);
  assign bus.running           = (state_r == ST_RUN) && !bus.timer_pause;
  assign bus.digital_clock_out = disp_r;

endmodule

// File: tb/tb_updown_bcd_timer.sv
// Bench for updown_bcd_timer: two instances (HR_MAX 99 and 23) share one
// stimulus stream and are compared every cycle to a seconds-based model.
module tb_updown_bcd_timer;
  localparam int DIV = 10;

  logic        sys_clk = 1'b0;
  logic        rst_b;
  logic        clr, pau, sta, cdn, lv;
  logic [23:0] lbcd;

  always #5 sys_clk = ~sys_clk;

  updown_bcd_timer_if bus0();
  updown_bcd_timer_if bus1();

  assign bus0.timer_clear = clr;  assign bus1.timer_clear = clr;
  assign bus0.timer_pause = pau;  assign bus1.timer_pause = pau;
  assign bus0.timer_start = sta;  assign bus1.timer_start = sta;
  assign bus0.count_down  = cdn;  assign bus1.count_down  = cdn;
  assign bus0.load_valid  = lv;   assign bus1.load_valid  = lv;
  assign bus0.load_bcd    = lbcd; assign bus1.load_bcd    = lbcd;
`ifdef UPDOWN_TIMER_LAP_EN
  assign bus0.lap_hold    = 1'b0; assign bus1.lap_hold    = 1'b0;
`endif

  updown_bcd_timer #(.CLK_DIV(DIV), .HR_MAX(99)) dut0 (.sys_clk(sys_clk), .rst_b(rst_b), .bus(bus0));
  updown_bcd_timer #(.CLK_DIV(DIV), .HR_MAX(23)) dut1 (.sys_clk(sys_clk), .rst_b(rst_b), .bus(bus1));

  // model: state 0 idle, 1 run, 2 expired; count kept as plain seconds
  int  hr_max  [2] = '{99, 23};
  int  m_state [2], m_secs [2], m_down [2], m_presc [2], m_shown [2];
  bit  m_wrap  [2], m_lerr [2];
  int  n_checks = 0, n_errors = 0;
  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] secs_to_bcd(input int s);
    int h, m, x;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic logic [41:0] disp_of(input int s);
    logic [23:0] b;
    logic [41:0] r;
    b = secs_to_bcd(s);
    for (int i = 0; i < 6; i++) r[i*7 +: 7] = seg_tab[int'(b[i*4 +: 4])];
    return r;
  endfunction

  task automatic decode_load(input logic [23:0] b, input int hm, output bit ok, output int secs);
    int d [6];
    for (int i = 0; i < 6; i++) d[i] = int'(b[i*4 +: 4]);
    ok = (d[0] <= 9) && (d[2] <= 9) && (d[4] <= 9) && (d[5] <= 9) &&
         (d[1] <= 5) && (d[3] <= 5) && ((d[5] * 10 + d[4]) <= hm);
    secs = (d[5] * 10 + d[4]) * 3600 + (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
  endtask

  task automatic model_step(input int i);
    bit ok;
    int val;
    m_wrap[i] = 1'b0;
    m_lerr[i] = 1'b0;
    if (!rst_b) begin
      m_state[i] = 0; m_secs[i] = 0; m_presc[i] = 0; m_shown[i] = 0; m_down[i] = 0;
      return;
    end
    m_shown[i] = m_secs[i];
    if (clr) begin
      m_state[i] = 0; m_secs[i] = 0; m_presc[i] = 0;
      return;
    end
    if (lv && m_state[i] == 1) m_lerr[i] = 1'b1;
    if (lv && m_state[i] != 1) begin
      decode_load(lbcd, hr_max[i], ok, val);
      if (ok) begin
        m_secs[i] = val; m_presc[i] = 0; m_state[i] = 0;
      end else begin
        m_lerr[i] = 1'b1;
      end
    end else if (sta && m_state[i] != 1) begin
      if ((m_state[i] == 0 && !(cdn && m_secs[i] == 0)) || (m_state[i] == 2 && m_secs[i] != 0)) begin
        m_state[i] = 1; m_down[i] = cdn;
      end
    end else if (m_state[i] == 1 && !pau) begin
      if (m_presc[i] == DIV - 1) begin
        m_presc[i] = 0;
        if (m_down[i] != 0) begin
          m_secs[i] = m_secs[i] - 1;
          if (m_secs[i] == 0) m_state[i] = 2;
        end else begin
          m_secs[i] = (m_secs[i] + 1) % ((hr_max[i] + 1) * 3600);
          if (m_secs[i] == 0) m_wrap[i] = 1'b1;
        end
      end else begin
        m_presc[i] = m_presc[i] + 1;
      end
    end
  endtask

  task automatic cmp_outputs(input int i, input logic [41:0] disp, input logic exp_o,
                             input logic run_o, input logic wrap_o, input logic lerr_o);
    check_val($sformatf("disp%0d", i), disp, disp_of(m_shown[i]));
    check_val($sformatf("expired%0d", i), exp_o, m_state[i] == 2);
    check_val($sformatf("running%0d", i), run_o, (m_state[i] == 1) && !pau);
    check_val($sformatf("wrap%0d", i), wrap_o, m_wrap[i]);
    check_val($sformatf("load_err%0d", i), lerr_o, m_lerr[i]);
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_step(0);
    model_step(1);
    #1;
    cmp_outputs(0, bus0.digital_clock_out, bus0.expired, bus0.running, bus0.wrap_pulse, bus0.load_err);
    cmp_outputs(1, bus1.digital_clock_out, bus1.expired, bus1.running, bus1.wrap_pulse, bus1.load_err);
    @(negedge sys_clk);
    sta = 1'b0;
    lv  = 1'b0;
  endtask

  task automatic load_and_start(input logic [23:0] v, input logic down);
    clr = 1'b1; step(); clr = 1'b0;
    lv = 1'b1; lbcd = v; step();
    sta = 1'b1; cdn = down; step();
  endtask

  initial begin
    int first, wraps, rise;
    logic [41:0] disp_at;
    rst_b = 1'b0; clr = 1'b0; pau = 1'b0; sta = 1'b0; cdn = 1'b0; lv = 1'b0; lbcd = 24'd0;
    @(negedge sys_clk);
    step(); step();
    check_val("reset_disp", bus0.digital_clock_out, {6{7'b0000001}});
    rst_b = 1'b1;
    step();

    // first tick latency in up mode from zero
    sta = 1'b1; cdn = 1'b0; step();
    first = -1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (first < 0 && bus0.digital_clock_out != disp_of(0)) first = k;
    end
    check_val("up_first_tick", first, 11);
    check_val("up_running", bus0.running, 1'b1);

    // rollover from 99:59:58
    load_and_start(24'h995958, 1'b0);
    wraps = 0; disp_at = '0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (bus0.wrap_pulse) wraps++;
      if (k == 20) check_val("wrap_at_20", bus0.wrap_pulse, 1'b1);
      if (k == 21) disp_at = bus0.digital_clock_out;
    end
    check_val("wrap_count", wraps, 1);
    check_val("wrap_disp", disp_at, disp_of(0));
    check_val("wrap_still_run", bus0.running, 1'b1);

    // countdown from 00:00:02 to expiry
    load_and_start(24'h000002, 1'b1);
    rise = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (rise < 0 && bus0.expired) rise = k;
      if (k == 21) disp_at = bus0.digital_clock_out;
    end
    check_val("expire_latency", rise, 20);
    check_val("expire_disp", disp_at, disp_of(0));
    check_val("expire_hold", bus0.digital_clock_out, disp_of(0));

    // down start at zero is ignored
    clr = 1'b1; step(); clr = 1'b0;
    sta = 1'b1; cdn = 1'b1; step();
    check_val("down_zero_idle", bus0.running, 1'b0);

    // 35-cycle pause delays the tick by 35 cycles
    clr = 1'b1; step(); clr = 1'b0;
    sta = 1'b1; cdn = 1'b0; step();
    first = -1;
    for (int k = 1; k <= 60; k++) begin
      pau = (k >= 5 && k < 40);
      step();
      if (k == 20) check_val("pause_running", bus0.running, 1'b0);
      if (first < 0 && bus0.digital_clock_out != disp_of(0)) first = k;
    end
    pau = 1'b0;
    check_val("pause_tick", first, 46);

    // rejected loads
    clr = 1'b1; step(); clr = 1'b0;
    lv = 1'b1; lbcd = 24'h006000; step();
    check_val("lerr_min60", bus0.load_err, 1'b1);
    lv = 1'b1; lbcd = 24'h240000; step();
    check_val("lerr_hr24_h23", bus1.load_err, 1'b1);
    check_val("lok_hr24_h99", bus0.load_err, 1'b0);
    sta = 1'b1; cdn = 1'b0; step(); step(); step();
    lv = 1'b1; lbcd = 24'h000005; step();
    check_val("lerr_in_run", bus0.load_err, 1'b1);
    step(); step();

    // clear + load + tick on one cycle
    clr = 1'b1; step(); clr = 1'b0;
    sta = 1'b1; cdn = 1'b0; step();
    for (int k = 0; k < 20 && m_presc[0] != DIV - 1; k++) step();
    clr = 1'b1; lv = 1'b1; lbcd = 24'h123456; step(); clr = 1'b0;
    check_val("clr_prio_lerr", bus0.load_err, 1'b0);
    check_val("clr_prio_run", bus0.running, 1'b0);
    step();
    check_val("clr_prio_disp", bus0.digital_clock_out, disp_of(0));

    // randomized phase
    for (int n = 0; n < 2500; n++) begin
      clr = ($urandom_range(0, 99) < 2);
      lv  = ($urandom_range(0, 99) < 5);
      sta = ($urandom_range(0, 99) < 10);
      cdn = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 15) == 0) pau = ~pau;
      case ($urandom_range(0, 3))
        0:       lbcd = secs_to_bcd($urandom_range(0, 4));
        1:       lbcd = secs_to_bcd(99 * 3600 + 3599 - $urandom_range(0, 2));
        2:       lbcd = secs_to_bcd(23 * 3600 + 3599 - $urandom_range(0, 2));
        default: lbcd = 24'($urandom());
      endcase
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/updown_bcd_timer.md
# updown_bcd_timer

Parametrised successor to the fixed-rate up-counting HH:MM:SS timer. It adds a configurable tick divider, a configurable hour ceiling, a run-time selectable count-up or count-down mode, and a preloadable start value. It raises an expiry indication when a countdown reaches zero. It drives six active-low seven-segment digits directly and sits between the board clock and the display pins.

## Interface
- `CLK_DIV`, default 10: sys_clk cycles per one-second tick; legal range 2..2^24.
- `HR_MAX`, default 99: highest hour value; legal range 1..99.
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `rst_b`  in  1  reset; synchronous, active-low.
- `timer_clear`  in  1  level; forces count to 00:00:00 and state to IDLE.
- `timer_pause`  in  1  level; freezes prescaler and count while in RUN.
- `timer_start`  in  1  pulse; IDLE→RUN.
- `count_down`  in  1  mode; 0 counts up, 1 counts down. Sampled only on the `timer_start` cycle.
- `load_valid`  in  1  pulse; loads `load_bcd` into the count.
- `load_bcd`  in  24  packed BCD; [23:20] hour tens … [3:0] second units.
- `load_err`  out  1  one-cycle pulse; the load was rejected.
- `running`  out  1  high in RUN with `timer_pause` low.
- `expired`  out  1  level; high in EXPIRED.
- `wrap_pulse`  out  1  one-cycle pulse on count-up rollover.
- `digital_clock_out`  out  [5:0][6:0]  segments {a..g}, active-low. Index 0 is seconds units; index 5 is hours tens.

## Operation
- Internal count: six 4-bit BCD digits. Second and minute tens digits range 0..5; hours range 0..HR_MAX.
- Segment encoding, digits 0-9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
- FSM states:
  - IDLE → RUN on `timer_start`. The latched mode comes from `count_down`.
  - RUN → EXPIRED when, in down mode, a tick takes the count to 00:00:00.
  - RUN → IDLE on `timer_clear`.
  - EXPIRED → IDLE on `timer_clear`, or on `load_valid` accepted.
  - EXPIRED → RUN on `timer_start` when the count is non-zero, after a load.
- Prescaler counts 0..CLK_DIV-1 only in RUN with pause low. A tick fires on the cycle where it equals CLK_DIV-1; it then returns to 0.
- Up mode: increment with BCD carry through digits. HR_MAX:59:59 + tick → 00:00:00, with `wrap_pulse` for one cycle. Stays in RUN.
- Down mode: decrement with BCD borrow. Reaching 00:00:00 enters EXPIRED and holds zero.
- `timer_start` in down mode with count 00:00:00 is ignored; the FSM stays IDLE.
- Load rules:
  - Accepted in IDLE or EXPIRED only.
  - Rejected, with `load_err`, if any unit digit > 9, any tens digit for seconds or minutes > 5, or hours > HR_MAX.
  - A load in RUN is ignored, with `load_err`.
  - An accepted load clears the prescaler.
- Priority per cycle: `rst_b` low > `timer_clear` > `load_valid` > `timer_start` > tick.
- Pause asserted on the same cycle as a would-be tick suppresses that tick; the prescaler holds CLK_DIV-1.

## Timing
- Reset values, set on the first sys_clk edge with `rst_b` low:
  - state IDLE, count 00:00:00, prescaler 0;
  - `digital_clock_out` = six × 0000001;
  - `expired`, `running`, `wrap_pulse`, `load_err` = 0.
- Count updates on the edge ending the tick cycle.
- `digital_clock_out` is registered from the count, so it lags the count by one cycle.
- `expired` rises together with the count reaching zero, i.e. one cycle before the display shows 00:00:00.
- `wrap_pulse` is high for the cycle after the rollover edge.
- `load_err` is high for the cycle after the offending `load_valid`.
- Count is visible on the display 2 cycles after `load_valid`.
- `timer_start` → first tick: exactly CLK_DIV cycles with no pause.
- `timer_clear` or reset mid-tick discards the partial prescaler count.

## Configuration
- `UPDOWN_TIMER_LAP_EN` defined:
  - Adds input `lap_hold`, 1 bit, level.
  - While high, `digital_clock_out` freezes at the value shown when it rose; the count continues.
  - On release, the display shows the live count one cycle later.
  - `timer_clear` overrides the freeze.
- Macro undefined: port absent; the display always tracks the count.

## Test plan
- Reset, CLK_DIV=10, start in up mode: display changes 00:00:00→00:00:01 exactly 11 cycles after the start edge; `running`=1.
- Load 99:59:58, start up: after 20 cycles the count reads 00:00:00; `wrap_pulse` is one cycle; state stays RUN.
- Load 00:00:02, start down: `expired` rises 20 cycles after start; display reads 00:00:00 next cycle; further ticks leave the count at zero.
- Pause high for 35 cycles mid-run: the next tick is delayed by exactly 35 cycles; `running`=0 during the pause.
- Load 00:60:00, load in RUN, and load hours 24 with HR_MAX=23: each gives a `load_err` pulse and leaves the count unchanged.
- `timer_clear` together with `load_valid` and a tick on the same cycle: result is count 00:00:00, state IDLE, no `load_err`.
